// File: rtl/vid_timing_pkg.sv
// Shared definitions for the DSI TX video timing controller and generator wrapper.
//   - ctrl_state_t : controller run/stop state encoding
//   - TIM_*        : default field widths
//   - DEF_*        : 640x480@60 power-on timing
//   - timing_cfg_t : timing record at default widths
//   - cfg_word_width(): width of the packed config word
//     (layout, MSB..LSB: hsync, hbp, hact, hfp, vsync, vbp, vact, vfp, frames)
package vid_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RELOAD,
    ST_RUN
  } ctrl_state_t;

  localparam int unsigned TIM_PW  = 14;
  localparam int unsigned TIM_VW  = 12;
  localparam int unsigned TIM_FCW = 16;

  localparam logic [7:0]  DEF_HSYNC = 8'd96;
  localparam logic [7:0]  DEF_HBP   = 8'd48;
  localparam int unsigned DEF_HACT  = 640;
  localparam logic [7:0]  DEF_HFP   = 8'd16;
  localparam logic [7:0]  DEF_VSYNC = 8'd2;
  localparam logic [7:0]  DEF_VBP   = 8'd33;
  localparam int unsigned DEF_VACT  = 480;
  localparam logic [7:0]  DEF_VFP   = 8'd10;

  typedef struct packed {
    logic [7:0]         hsync;
    logic [7:0]         hbp;
    logic [TIM_PW-1:0]  hact;
    logic [7:0]         hfp;
    logic [7:0]         vsync;
    logic [7:0]         vbp;
    logic [TIM_VW-1:0]  vact;
    logic [7:0]         vfp;
    logic [TIM_FCW-1:0] frames;
  } timing_cfg_t;

  function automatic int unsigned cfg_word_width(int unsigned pw, int unsigned vw,
                                                 int unsigned fcw);
    return 6 * 8 + pw + vw + fcw;
  endfunction

endpackage

// File: rtl/vid_timing_shadow.sv
// Config shadow register with valid/ready capture and validation.
//   in_pclk, in_rst : clock, synchronous active-high reset
//   cfg_valid/ready : host handshake; ready whenever no config is pending
//   cfg_word        : packed config (see vid_timing_pkg layout)
//   consume         : controller has copied the shadow into the active set
//   pending         : shadow holds a config not yet applied
//   sh_word         : shadow contents
//   cfg_err         : one-cycle pulse after a config with zero hact or vact
module vid_timing_shadow
  import vid_timing_pkg::*;
#(
  parameter int unsigned PW  = TIM_PW,
  parameter int unsigned VW  = TIM_VW,
  parameter int unsigned FCW = TIM_FCW,
  localparam int unsigned DW = cfg_word_width(PW, VW, FCW)
) (
  input  logic          in_pclk,
  input  logic          in_rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_word,
  input  logic          consume,
  output logic          pending,
  output logic [DW-1:0] sh_word,
  output logic          cfg_err
);

  localparam int unsigned O_VACT = FCW + 8;
  localparam int unsigned O_HACT = FCW + 8 + VW + 24;

  logic          pend_q;
  logic          err_q;
  logic [DW-1:0] word_q;
  logic          xfer;
  logic          cfg_ok;

  assign xfer   = cfg_valid & ~pend_q;
  assign cfg_ok = (|cfg_word[O_HACT +: PW]) & (|cfg_word[O_VACT +: VW]);

  // Bad configs still complete the handshake so the host never stalls on them.
  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      word_q <= '0;
    end else begin
      err_q <= xfer & ~cfg_ok;
      if (xfer && cfg_ok) begin
        word_q <= cfg_word;
        pend_q <= 1'b1;
      end else if (consume) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign cfg_ready = ~pend_q;
  assign pending   = pend_q;
  assign sh_word   = word_q;
  assign cfg_err   = err_q;

endmodule

// File: rtl/vid_timing_ctrl.sv
// Run/stop and mode-switch controller for the DSI TX video timing generator.
//   in_pclk, in_rst     : pixel clock, synchronous active-high reset
//   cfg_*               : host timing config with valid/ready handshake
//   cfg_frames          : frames per burst, 0 = continuous
//   start, stop         : single-cycle run / graceful stop requests
//   gen_vs              : generator VS (active low); its falling edge ends a frame
//   gen_rstn            : generator reset, active low (high only in RUN)
//   act_*               : timing currently driven to the generator
//   busy, frame_cnt     : not idle, frames completed in the current run
//   done, cfg_err       : one-cycle run-complete / rejected-config pulses
module vid_timing_ctrl
  import vid_timing_pkg::*;
#(
  parameter int unsigned PW         = TIM_PW,
  parameter int unsigned VW         = TIM_VW,
  parameter int unsigned FCW        = TIM_FCW,
  parameter int unsigned RELOAD_CYC = 2
) (
  input  logic           in_pclk,
  input  logic           in_rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [7:0]     cfg_hsync,
  input  logic [7:0]     cfg_hbp,
  input  logic [PW-1:0]  cfg_hact,
  input  logic [7:0]     cfg_hfp,
  input  logic [7:0]     cfg_vsync,
  input  logic [7:0]     cfg_vbp,
  input  logic [VW-1:0]  cfg_vact,
  input  logic [7:0]     cfg_vfp,
  input  logic [FCW-1:0] cfg_frames,
  input  logic           start,
  input  logic           stop,
  input  logic           gen_vs,
  output logic           gen_rstn,
  output logic [7:0]     act_hsync,
  output logic [7:0]     act_hbp,
  output logic [PW-1:0]  act_hact,
  output logic [7:0]     act_hfp,
  output logic [7:0]     act_vsync,
  output logic [7:0]     act_vbp,
  output logic [VW-1:0]  act_vact,
  output logic [7:0]     act_vfp,
  output logic           busy,
  output logic [FCW-1:0] frame_cnt,
  output logic           done,
  output logic           cfg_err
);

  localparam int unsigned DW      = cfg_word_width(PW, VW, FCW);
  localparam int unsigned O_VFP   = FCW;
  localparam int unsigned O_VACT  = O_VFP + 8;
  localparam int unsigned O_VBP   = O_VACT + VW;
  localparam int unsigned O_VSYNC = O_VBP + 8;
  localparam int unsigned O_HFP   = O_VSYNC + 8;
  localparam int unsigned O_HACT  = O_HFP + 8;
  localparam int unsigned O_HBP   = O_HACT + PW;
  localparam int unsigned O_HSYNC = O_HBP + 8;
  localparam int unsigned RCW     = (RELOAD_CYC > 1) ? $clog2(RELOAD_CYC) : 1;
  localparam logic [RCW-1:0] RLAST = RCW'(RELOAD_CYC - 1);

  localparam logic [DW-1:0] DEF_WORD = {DEF_HSYNC, DEF_HBP, PW'(DEF_HACT), DEF_HFP,
                                        DEF_VSYNC, DEF_VBP, VW'(DEF_VACT), DEF_VFP,
                                        {FCW{1'b0}}};

  ctrl_state_t    state_q, state_n;
  logic [RCW-1:0] rcnt_q, rcnt_n;
  logic [FCW-1:0] fcnt_q, fcnt_n, fcnt_inc;
  logic           stop_q, stop_n;
  logic           done_q, done_n;
  logic           vs_q;
  logic [DW-1:0]  act_q;
  logic [DW-1:0]  cfg_word, sh_word;
  logic           sh_pending;
  logic           apply;
  logic           fe;

  assign cfg_word = {cfg_hsync, cfg_hbp, cfg_hact, cfg_hfp,
                     cfg_vsync, cfg_vbp, cfg_vact, cfg_vfp, cfg_frames};

  vid_timing_shadow #(
    .PW  (PW),
    .VW  (VW),
    .FCW (FCW)
  ) u_shadow (
    .in_pclk   (in_pclk),
    .in_rst    (in_rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_word  (cfg_word),
    .consume   (apply),
    .pending   (sh_pending),
    .sh_word   (sh_word),
    .cfg_err   (cfg_err)
  );

  assign fe       = (state_q == ST_RUN) & vs_q & ~gen_vs;
  assign fcnt_inc = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;

  always_comb begin
    state_n = state_q;
    rcnt_n  = rcnt_q;
    fcnt_n  = fcnt_q;
    stop_n  = stop_q;
    done_n  = 1'b0;
    apply   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stop_n = 1'b0;
        apply  = sh_pending;
        if (start) begin
          state_n = ST_RELOAD;
          rcnt_n  = '0;
          fcnt_n  = '0;
        end
      end
      ST_RELOAD: begin
        stop_n = 1'b0;
        if (stop) begin
          state_n = ST_IDLE;
        end else if (rcnt_q == RLAST) begin
          state_n = ST_RUN;
        end else begin
          rcnt_n = rcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        stop_n = stop_q | stop;
        // A stop arriving on the frame-end cycle itself is honoured at that
        // frame end rather than being lost across a reload.
        if (fe) begin
          fcnt_n = fcnt_inc;
          if (stop_q || stop) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            stop_n  = 1'b0;
          end else if ((act_q[FCW-1:0] != '0) && (fcnt_inc == act_q[FCW-1:0])) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            stop_n  = 1'b0;
          end else if (sh_pending) begin
            apply   = 1'b1;
            state_n = ST_RELOAD;
            rcnt_n  = '0;
            stop_n  = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      fcnt_q  <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      vs_q    <= 1'b1;
      act_q   <= DEF_WORD;
    end else begin
      state_q <= state_n;
      rcnt_q  <= rcnt_n;
      fcnt_q  <= fcnt_n;
      stop_q  <= stop_n;
      done_q  <= done_n;
      vs_q    <= gen_vs;
      if (apply) act_q <= sh_word;
    end
  end

  assign gen_rstn  = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = fcnt_q;
  assign done      = done_q;

  assign act_hsync = act_q[O_HSYNC +: 8];
  assign act_hbp   = act_q[O_HBP   +: 8];
  assign act_hact  = act_q[O_HACT  +: PW];
  assign act_hfp   = act_q[O_HFP   +: 8];
  assign act_vsync = act_q[O_VSYNC +: 8];
  assign act_vbp   = act_q[O_VBP   +: 8];
  assign act_vact  = act_q[O_VACT  +: VW];
  assign act_vfp   = act_q[O_VFP   +: 8];

endmodule
